// File: rtl/opb_pkg.sv
// Shared OPB definitions: bus width defaults, master state encoding and the
// register map of the board's OPB peripherals.
// Optional feature macro: OPB_CMD_MASTER_WRVERIFY_EN (adds the VFY_RD state).
package opb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

  // Peripheral register addresses
  localparam logic [ADDR_W_DEF-1:0] REG_CLK_DIV     = 4'd1;
  localparam logic [ADDR_W_DEF-1:0] REG_SAMPLE_TIME = 4'd2;
  localparam logic [ADDR_W_DEF-1:0] REG_SAMPLE_TRIG = 4'd3;
  localparam logic [ADDR_W_DEF-1:0] REG_FAULT       = 4'd4;
  localparam logic [ADDR_W_DEF-1:0] REG_ENABLE      = 4'd5;
  localparam logic [ADDR_W_DEF-1:0] REG_POLARITY    = 4'd6;
  localparam logic [ADDR_W_DEF-1:0] REG_CYCLE_CNT   = 4'd7;
  localparam logic [ADDR_W_DEF-1:0] REG_OC_SET      = 4'd8;

  // Command master states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR     = 3'd1,
    ST_RD     = 3'd2,
`ifdef OPB_CMD_MASTER_WRVERIFY_EN
    ST_RESP   = 3'd3,
    ST_VFY_RD = 3'd4
`else
    ST_RESP   = 3'd3
`endif
  } opb_state_t;

endpackage

// File: rtl/opb_cmd_master.sv
// Single-outstanding OPB bus master: turns a valid/ready command stream into
// OPB register writes/reads and returns one response per command.
// Optional feature macro: OPB_CMD_MASTER_WRVERIFY_EN -- every write is followed
// by a readback of the same address; RSP_DATA carries the readback and RSP_ERR
// flags a mismatch. Without it RSP_ERR is tied low.
//
// Handshakes: a transfer on CMD_* or RSP_* happens at a rising OPB_CLK edge
// where VALID and READY are both high; VALID holds its payload until then.
module opb_cmd_master
  import opb_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              OPB_CLK,
  input  logic              OPB_RSTb,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_ERR,
  output logic [ADDR_W-1:0] OPB_ADDR,
  output logic [DATA_W-1:0] OPB_DI,
  input  logic [DATA_W-1:0] OPB_DO,
  output logic              OPB_WE,
  output logic              OPB_RE,
  output logic              BUSY,
  output opb_state_t        DBG_STATE
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  opb_state_t        state_q, state_d;
  logic              run_q;       // low while in reset and until the first edge after it
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        cnt_q;       // remaining RE cycles after the current one
  logic [DATA_W-1:0] rsp_data_q;
  logic              accept;
  logic              we_cyc;
  logic              re_cyc;

  // The direction of the latched command is carried by the state itself
  // (WR vs RD), so no separate write flag register is kept.
  assign accept = CMD_VALID && CMD_READY;
  assign we_cyc = (state_q == ST_WR);
`ifdef OPB_CMD_MASTER_WRVERIFY_EN
  assign re_cyc = (state_q == ST_RD) || (state_q == ST_VFY_RD);
`else
  assign re_cyc = (state_q == ST_RD);
`endif

  // State register; async reset drops the strobes immediately.
  always_ff @(posedge OPB_CLK or negedge OPB_RSTb) begin
    if (!OPB_RSTb) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = CMD_WRITE ? ST_WR : ST_RD;
`ifdef OPB_CMD_MASTER_WRVERIFY_EN
      ST_WR:     state_d = ST_VFY_RD;
      ST_VFY_RD: if (cnt_q == 4'd0) state_d = ST_RESP;
`else
      ST_WR:     state_d = ST_RESP;
`endif
      ST_RD:   if (cnt_q == 4'd0) state_d = ST_RESP;
      ST_RESP: if (RSP_READY) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, wait counter and response capture.
  always_ff @(posedge OPB_CLK or negedge OPB_RSTb) begin
    if (!OPB_RSTb) begin
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= 4'd0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= CMD_ADDR;
            data_q <= CMD_DATA;
            cnt_q  <= WAIT_LOAD;
          end
        end
        ST_WR: begin
          rsp_data_q <= data_q;
          cnt_q      <= WAIT_LOAD;
        end
        ST_RESP: ;
        default: begin
          // RD / VFY_RD: capture on the edge that ends the last RE cycle
          if (cnt_q == 4'd0) rsp_data_q <= OPB_DO;
          else               cnt_q      <= cnt_q - 4'd1;
        end
      endcase
    end
  end

`ifdef OPB_CMD_MASTER_WRVERIFY_EN
  logic rsp_err_q;

  // Readback mismatch flag, computed on the full data width.
  always_ff @(posedge OPB_CLK or negedge OPB_RSTb) begin
    if (!OPB_RSTb) begin
      rsp_err_q <= 1'b0;
    end else if (re_cyc && cnt_q == 4'd0) begin
      rsp_err_q <= (state_q == ST_VFY_RD) && (OPB_DO != data_q);
    end
  end

  assign RSP_ERR = rsp_err_q;
`else
  assign RSP_ERR = 1'b0;
`endif

  assign CMD_READY = run_q && (state_q == ST_IDLE);
  assign RSP_VALID = (state_q == ST_RESP);
  assign RSP_DATA  = rsp_data_q;
  assign OPB_WE    = we_cyc;
  assign OPB_RE    = re_cyc;
  assign OPB_ADDR  = (we_cyc || re_cyc) ? addr_q : '0;
  assign OPB_DI    = we_cyc ? data_q : '0;
  assign BUSY      = (state_q != ST_IDLE);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_opb_cmd_master.sv
// Bench for opb_cmd_master: a peripheral register model on the OPB side,
// directed scenarios followed by random commands, expected responses kept in
// a queue computed from a simple register-file reference.
// Honours OPB_CMD_MASTER_WRVERIFY_EN when the build defines it.
module tb_opb_cmd_master;
  import opb_pkg::*;

  localparam int WS = 3;

  logic        OPB_CLK;
  logic        OPB_RSTb;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_WRITE;
  logic [3:0]  CMD_ADDR;
  logic [31:0] CMD_DATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [31:0] RSP_DATA;
  logic        RSP_ERR;
  logic [3:0]  OPB_ADDR;
  logic [31:0] OPB_DI;
  logic [31:0] OPB_DO;
  logic        OPB_WE;
  logic        OPB_RE;
  logic        BUSY;
  opb_state_t  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [16];   // what each register should hold
  logic [31:0] per_mem [16];   // peripheral model storage, written over the bus
  int          re_seen;

  opb_cmd_master #(.WAIT_STATES(WS), .ADDR_W(4), .DATA_W(32)) dut (
    .OPB_CLK(OPB_CLK), .OPB_RSTb(OPB_RSTb),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .OPB_ADDR(OPB_ADDR), .OPB_DI(OPB_DI), .OPB_DO(OPB_DO),
    .OPB_WE(OPB_WE), .OPB_RE(OPB_RE), .BUSY(BUSY), .DBG_STATE(dbg_state)
  );

  // ---------------- clock ----------------
  initial OPB_CLK = 1'b0;
  always #5 OPB_CLK = ~OPB_CLK;

  // ---------------- peripheral model ----------------
  // Writes latch on the falling edge; register 4 is a fault register that reads 0.
  always @(negedge OPB_CLK) if (OPB_WE) per_mem[OPB_ADDR] <= OPB_DI;

  // Read data only becomes valid on the last allowed RE cycle (slow peripheral).
  always @(posedge OPB_CLK or negedge OPB_RSTb) begin
    if (!OPB_RSTb)   re_seen <= 0;
    else if (OPB_RE) re_seen <= re_seen + 1;
    else             re_seen <= 0;
  end

  assign OPB_DO = (OPB_RE && re_seen == WS) ?
                  ((OPB_ADDR == 4'd4) ? 32'h0 : per_mem[OPB_ADDR]) : 32'hDEAD_BEEF;

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [3:0] a);
    return (a == 4'd4) ? 32'h0 : ref_mem[a];
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge. Issues one command, checks bus activity
  // and response timing, holds RSP_READY low for 'hold' cycles (optionally
  // presenting the next command meanwhile), then completes the handshake.
  task automatic do_cmd(input logic w, input logic [3:0] a, input logic [31:0] d,
                        input int hold, input logic qn, input logic qw,
                        input logic [3:0] qa, input logic [31:0] qd);
    logic [31:0] exp_d, got_d;
    logic        exp_e, got_e;
    int exp_lat, exp_we, exp_re, exp_re_first;
    int n, cyc, we_n, re_n, we_first, re_first;

    if (w) begin
      ref_mem[a] = d;
      exp_we = 1;
`ifdef OPB_CMD_MASTER_WRVERIFY_EN
      exp_d = ref_read(a); exp_e = (exp_d != d);
      exp_lat = 3 + WS; exp_re = WS + 1; exp_re_first = 2;
`else
      exp_d = d; exp_e = 1'b0;
      exp_lat = 2; exp_re = 0; exp_re_first = 0;
`endif
    end else begin
      exp_d = ref_read(a); exp_e = 1'b0;
      exp_lat = 2 + WS; exp_we = 0; exp_re = WS + 1; exp_re_first = 1;
    end
    exp_q.push_back(exp_d);

    CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_DATA = d;
    n = 0;
    while (!CMD_READY && n < 20) begin
      @(negedge OPB_CLK); n++;
    end
    if (!CMD_READY) begin
      chk1("cmd_ready_timeout", CMD_READY, 1'b1);
      CMD_VALID = 1'b0;
      void'(exp_q.pop_back());
      return;
    end

    @(negedge OPB_CLK);
    CMD_VALID = 1'b0;
    cyc = 1; we_n = 0; re_n = 0; we_first = 0; re_first = 0;
    while (!RSP_VALID && cyc < 40) begin
      chk1("cmd_ready_busy", CMD_READY, 1'b0);
      chk1("busy_high", BUSY, 1'b1);
      chk1("we_re_excl", OPB_WE & OPB_RE, 1'b0);
      if (OPB_WE) begin
        we_n++; if (we_first == 0) we_first = cyc;
        chk("we_addr", 32'(OPB_ADDR), 32'(a));
        chk("we_data", OPB_DI, d);
      end
      if (OPB_RE) begin
        re_n++; if (re_first == 0) re_first = cyc;
        chk("re_addr", 32'(OPB_ADDR), 32'(a));
        chk("re_di_idle", OPB_DI, 32'h0);
      end
      if (!OPB_WE && !OPB_RE) begin
        chk("addr_idle", 32'(OPB_ADDR), 32'h0);
        chk("di_idle", OPB_DI, 32'h0);
      end
      @(negedge OPB_CLK); cyc++;
    end
    chk1("rsp_valid_seen", RSP_VALID, 1'b1);
    chk_int("rsp_latency", cyc, exp_lat);
    chk_int("we_count", we_n, exp_we);
    chk_int("re_count", re_n, exp_re);
    if (exp_we != 0) chk_int("we_first", we_first, 1);
    if (exp_re != 0) chk_int("re_first", re_first, exp_re_first);

    got_d = RSP_DATA; got_e = RSP_ERR;
    chk("rsp_data", got_d, exp_q.pop_front());
    chk1("rsp_err", got_e, exp_e);

    for (int i = 0; i < hold; i++) begin
      if (qn) begin
        CMD_VALID = 1'b1; CMD_WRITE = qw; CMD_ADDR = qa; CMD_DATA = qd;
      end
      @(negedge OPB_CLK);
      chk1("bp_rsp_valid", RSP_VALID, 1'b1);
      chk("bp_rsp_data", RSP_DATA, got_d);
      chk1("bp_rsp_err", RSP_ERR, got_e);
      chk1("bp_cmd_ready", CMD_READY, 1'b0);
      chk1("bp_no_we", OPB_WE, 1'b0);
      chk1("bp_no_re", OPB_RE, 1'b0);
    end

    RSP_READY = 1'b1;
    @(negedge OPB_CLK);
    RSP_READY = 1'b0;
    chk1("post_rsp_valid", RSP_VALID, 1'b0);
    chk1("post_cmd_ready", CMD_READY, 1'b1);
    chk1("post_busy", BUSY, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [3:0]  ra;
    logic [31:0] rd;
    logic        rw;

    OPB_RSTb = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0;
    CMD_ADDR = 4'd0; CMD_DATA = 32'h0; RSP_READY = 1'b0;

    // reset values
    @(negedge OPB_CLK); @(negedge OPB_CLK);
    chk1("rst_cmd_ready", CMD_READY, 1'b0);
    chk1("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_rsp_data", RSP_DATA, 32'h0);
    chk1("rst_rsp_err", RSP_ERR, 1'b0);
    chk("rst_opb_addr", 32'(OPB_ADDR), 32'h0);
    chk("rst_opb_di", OPB_DI, 32'h0);
    chk1("rst_we", OPB_WE, 1'b0);
    chk1("rst_re", OPB_RE, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk_int("rst_state", int'(dbg_state), int'(ST_IDLE));
    OPB_RSTb = 1'b1;
    #1 chk1("rel_cmd_ready_low", CMD_READY, 1'b0);
    @(negedge OPB_CLK);
    chk1("rel_cmd_ready_high", CMD_READY, 1'b1);

    // write cycle-count register
    do_cmd(1'b1, REG_CYCLE_CNT, 32'h0000_0960, 0, 1'b0, 1'b0, 4'd0, 32'h0);
    chk("per_mem7", per_mem[7], 32'h0000_0960);

    // read clk divider with backpressure and a queued follow-up read
    do_cmd(1'b1, REG_CLK_DIV, 32'h0000_0A6A, 0, 1'b0, 1'b0, 4'd0, 32'h0);
    do_cmd(1'b0, REG_CLK_DIV, 32'h0, 10, 1'b1, 1'b0, REG_CYCLE_CNT, 32'h0);
    do_cmd(1'b0, REG_CYCLE_CNT, 32'h0, 0, 1'b0, 1'b0, 4'd0, 32'h0);

    // populate every other register
    for (int i = 0; i < 16; i++) begin
      if (i != 1 && i != 7)
        do_cmd(1'b1, 4'(i), $urandom, 0, 1'b0, 1'b0, 4'd0, 32'h0);
    end

    // reset during the second RE cycle of a read
    CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = REG_SAMPLE_TRIG; CMD_DATA = 32'h0;
    for (int i = 0; i < 20 && !CMD_READY; i++) @(negedge OPB_CLK);
    @(negedge OPB_CLK);
    CMD_VALID = 1'b0;
    chk1("mid_re_cycle1", OPB_RE, 1'b1);
    @(negedge OPB_CLK);
    chk1("mid_re_cycle2", OPB_RE, 1'b1);
    OPB_RSTb = 1'b0;
    #1;
    chk1("abort_re", OPB_RE, 1'b0);
    chk1("abort_busy", BUSY, 1'b0);
    chk("abort_addr", 32'(OPB_ADDR), 32'h0);
    chk1("abort_cmd_ready", CMD_READY, 1'b0);
    @(negedge OPB_CLK); @(negedge OPB_CLK);
    OPB_RSTb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge OPB_CLK);
      chk1("abort_no_rsp", RSP_VALID, 1'b0);
      chk1("abort_no_re", OPB_RE, 1'b0);
    end
    chk1("abort_ready_again", CMD_READY, 1'b1);
    do_cmd(1'b0, REG_CLK_DIV, 32'h0, 1, 1'b0, 1'b0, 4'd0, 32'h0);

    // write then readback: polarity stores, fault register reads 0
    do_cmd(1'b1, REG_POLARITY, 32'h1, 0, 1'b0, 1'b0, 4'd0, 32'h0);
    do_cmd(1'b1, REG_FAULT, 32'h1, 0, 1'b0, 1'b0, 4'd0, 32'h0);

    // random traffic
    for (int i = 0; i < 24; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rd = $urandom;
      do_cmd(rw, ra, rd, $urandom_range(0, 3), 1'b0, 1'b0, 4'd0, 32'h0);
    end

    chk_int("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opb_cmd_master.md
# opb_cmd_master

Single-outstanding OPB bus master that converts a valid/ready command stream into OPB register writes and reads, and returns one response per command. It is the initiator side for the board's OPB register peripherals, such as the bridge/PWM controller, fault monitor and sample control. Peripherals decode `OPB_ADDR`, latch writes on the falling edge of `OPB_CLK`, and drive `OPB_DO` combinationally while `OPB_RE` is high. This block sits between the host command path and those peripherals.

## Interface
- `WAIT_STATES`, default 1: extra `OPB_CLK` cycles `OPB_RE` is held before read capture; legal range 0..15.
- `ADDR_W`, default 4: OPB address width.
- `DATA_W`, default 32: OPB data width.
- `OPB_CLK` in 1: single clock; all logic on its rising edge.
- `OPB_RSTb` in 1: reset, asynchronous and active-low.
- `CMD_VALID` in 1: command present.
- `CMD_READY` out 1: command accepted when both valid and ready are high at a rising edge.
- `CMD_WRITE` in 1: 1 = write, 0 = read.
- `CMD_ADDR` in `ADDR_W`: target register.
- `CMD_DATA` in `DATA_W`: write data; ignored for reads.
- `RSP_VALID` out 1: response present.
- `RSP_READY` in 1: response consumed when both valid and ready are high at a rising edge.
- `RSP_DATA` out `DATA_W`: read data, or echoed write data.
- `RSP_ERR` out 1: write-verify mismatch; only possible with the macro below.
- `OPB_ADDR` out `ADDR_W`: bus address.
- `OPB_DI` out `DATA_W`: write data toward the peripherals.
- `OPB_DO` in `DATA_W`: read data from the peripherals.
- `OPB_WE` out 1: write strobe.
- `OPB_RE` out 1: read enable.
- `BUSY` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, WR, RD, RESP; VFY_RD is added under the macro.
- **IDLE:**
  - `CMD_READY`=1.
  - On accept, latch addr, data and the write flag.
  - Go to WR if write, RD if read.
- **WR:**
  - `OPB_WE`=1 for exactly one cycle, with `OPB_ADDR`/`OPB_DI` = latched values.
  - Then go to RESP with `RSP_DATA`=write data and `RSP_ERR`=0.
- **RD:**
  - `OPB_RE`=1 and `OPB_ADDR`=latched addr for `WAIT_STATES`+1 cycles, counted by a 4-bit down-counter.
  - `OPB_DO` is captured at the rising edge that ends the last RE cycle.
  - Then go to RESP.
- **RESP:**
  - `RSP_VALID`=1; `RSP_DATA`/`RSP_ERR` are held stable until `RSP_READY`.
  - On handshake, return to IDLE.
- **Bus idling:** outside the strobe cycles, `OPB_ADDR`, `OPB_DI`, `OPB_WE` and `OPB_RE` are 0. `OPB_WE` and `OPB_RE` are never high together.
- **Outstanding commands:** one at a time; `CMD_READY` is low from acceptance until the response handshake completes.
- **Unmapped addresses:** a read of an unmapped address returns whatever `OPB_DO` carries; no timeout and no error.
- **Reset:**
  - Values: all outputs 0, state IDLE, counter 0.
  - Reset mid-transaction aborts immediately: the strobe drops asynchronously, the in-flight command is discarded and no response is produced.
  - After `OPB_RSTb` deasserts, `CMD_READY` rises at the first rising edge.

## Timing
- Command accepted at edge N.
- **Write:**
  - `OPB_WE` is high during cycle N+1; the peripheral latches it at the mid-cycle falling edge.
  - `RSP_VALID` is high from cycle N+2.
- **Read:**
  - `OPB_RE` is high during cycles N+1 .. N+1+`WAIT_STATES`.
  - `RSP_VALID` is high from cycle N+2+`WAIT_STATES`.
- **Back-to-back:** a response handshake at edge M raises `CMD_READY` in cycle M+1. There is no bypass, so the minimum spacing between commands is 3 cycles for writes and 3+`WAIT_STATES` for reads.

## Configuration
- **Macro:** `OPB_CMD_MASTER_WRVERIFY_EN`.
- **Defined:**
  - After WR, enter VFY_RD: a read of the same address using the RD timing, starting in cycle N+2.
  - `RSP_DATA` = readback value; `RSP_ERR` = (readback != write data), compared on all `DATA_W` bits.
  - Write response is valid from cycle N+3+`WAIT_STATES`.
  - Callers must avoid verify on write-only or self-clearing registers and on narrower registers whose upper bits read 0.
- **Undefined:** no VFY_RD state; `RSP_ERR` is tied 0; write response at N+2.

## Structure
- **Shared package `opb_pkg`:**
  - `ADDR_W`/`DATA_W` defaults.
  - State enum.
  - Peripheral register address constants: 1 clk divider, 2 sample time, 3 sample trigger, 4 fault, 5 enable, 6 polarity, 7 cycle count, 8 over-current set.
- **Sub-modules:** none; a single module with a state register, latched command, wait counter and capture register.

## Test plan
- **Write:** write addr 7, data 0x0000_0960, `WAIT_STATES`=1 → `OPB_WE` high exactly cycle N+1 with addr 7 and data 0x960; `RSP_VALID` at N+2 with data 0x960 and `RSP_ERR`=0; bench register model holds 0x960.
- **Read:** read addr 1 from a model holding 0x0A6A, `WAIT_STATES`=3 → `OPB_RE` high for 4 cycles; `RSP_DATA`=0x0000_0A6A at N+5; `OPB_WE` never high.
- **Backpressure:** `RSP_READY` held low 10 cycles → `RSP_VALID`/`RSP_DATA` stable, `CMD_READY` low throughout, second queued command not accepted until after the handshake.
- **Reset mid-read:** `OPB_RSTb` low during the 2nd RE cycle → `OPB_RE` and `BUSY` 0 immediately; no `RSP_VALID` after release; the next read completes normally.
- **Verify match (macro on):** write 0x1 to addr 6 against a model that stores it → response data 0x1, `RSP_ERR`=0, valid at N+3+`WAIT_STATES`.
- **Verify mismatch (macro on):** write 0x1 to addr 4 against a model that reads back 0x0 → `RSP_ERR`=1, `RSP_DATA`=0x0.
